// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, default width,
// and the early-out switch controlled by the DIV_EARLY_OUT_EN macro.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } div_state_t;

   localparam int DEFAULT_WIDTH = 32;

`ifdef DIV_EARLY_OUT_EN
   localparam bit EARLY_OUT_EN = 1'b1;
`else
   localparam bit EARLY_OUT_EN = 1'b0;
`endif

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem, quo} left, trial-subtract
// the divisor, keep the difference and set the quotient LSB when no borrow.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_nxt,
   output logic [WIDTH-1:0] quo_nxt
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           borrow;

   assign shifted = {rem, quo[WIDTH-1]};
   assign diff    = shifted - {1'b0, divisor};
   assign borrow  = diff[WIDTH];

   // The partial remainder stays below the divisor, so the kept value fits WIDTH bits.
   assign rem_nxt = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
   assign quo_nxt = {quo[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/iter_div.sv
// Iterative restoring divider with two independent operand channels and a
// valid-only result channel. Define DIV_EARLY_OUT_EN to skip ITER on trivial cases.
module iter_div
   import div_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter bit SIGNED = 1'b1
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
   input  logic               s_axis_dividend_tvalid,
   output logic               s_axis_dividend_tready,
   input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
   input  logic               s_axis_divisor_tvalid,
   output logic               s_axis_divisor_tready,
   output logic [2*WIDTH-1:0] m_axis_dout_tdata,
   output logic               m_axis_dout_tvalid
);

   div_state_t         state, state_nxt;
   logic [WIDTH-1:0]   dvd_q, dvs_q;
   logic               dvd_held, dvs_held;
   logic               dvd_hs, dvs_hs;
   logic               start;
   logic [WIDTH-1:0]   dvd_mag, dvs_mag;
   logic               early;
   logic [WIDTH-1:0]   rem_q, quo_q, dvs_mag_q, cnt_q;
   logic               quo_neg_q, rem_neg_q;
   logic [WIDTH-1:0]   step_rem, step_quo;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic [2*WIDTH-1:0] result, dout_q;

   assign s_axis_dividend_tready = (state == IDLE) & ~dvd_held;
   assign s_axis_divisor_tready  = (state == IDLE) & ~dvs_held;
   assign dvd_hs = s_axis_dividend_tvalid & s_axis_dividend_tready;
   assign dvs_hs = s_axis_divisor_tvalid  & s_axis_divisor_tready;

   assign dvd_mag = (SIGNED && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
   assign dvs_mag = (SIGNED && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
   assign early   = EARLY_OUT_EN && ((dvs_q == '0) || (dvd_mag < dvs_mag));

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         IDLE: if ((dvd_held | dvd_hs) && (dvs_held | dvs_hs)) begin
            state_nxt = PREP;
            start     = 1'b1;
         end
         PREP:    state_nxt = early ? DONE : ITER;
         ITER:    if (cnt_q == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= IDLE;
         dvd_held <= 1'b0;
         dvs_held <= 1'b0;
         cnt_q    <= '0;
         dout_q   <= '0;
      end else begin
         state <= state_nxt;
         if (start) begin
            dvd_held <= 1'b0;
            dvs_held <= 1'b0;
         end else begin
            if (dvd_hs) dvd_held <= 1'b1;
            if (dvs_hs) dvs_held <= 1'b1;
         end
         if (state == PREP)
            cnt_q <= WIDTH'(WIDTH - 1);
         else if (state == ITER && cnt_q != '0)
            cnt_q <= cnt_q - WIDTH'(1);
         if (state == DONE)
            dout_q <= result;
      end
   end

   // NOTE: datapath registers carry no reset; the held flags and FSM qualify every use.
   always_ff @(posedge clk) begin
      if (dvd_hs) dvd_q <= s_axis_dividend_tdata;
      if (dvs_hs) dvs_q <= s_axis_divisor_tdata;
      case (state)
         PREP: begin
            rem_q     <= early ? dvd_mag : '0;
            quo_q     <= early ? '0 : dvd_mag;
            dvs_mag_q <= dvs_mag;
            quo_neg_q <= SIGNED && (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
            rem_neg_q <= SIGNED && dvd_q[WIDTH-1];
         end
         ITER: begin
            rem_q <= step_rem;
            quo_q <= step_quo;
         end
         default: ;
      endcase
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem     (rem_q),
      .quo     (quo_q),
      .divisor (dvs_mag_q),
      .rem_nxt (step_rem),
      .quo_nxt (step_quo)
   );

   // Divide-by-zero overrides the sign fixup; the most-negative / -1 case falls out naturally.
   always_comb begin
      quo_fix = quo_neg_q ? -quo_q : quo_q;
      rem_fix = rem_neg_q ? -rem_q : rem_q;
      result  = {quo_fix, rem_fix};
      if (dvs_q == '0)
         result = {{WIDTH{1'b1}}, dvd_q};
   end

   assign m_axis_dout_tvalid = (state == DONE);
   assign m_axis_dout_tdata  = (state == DONE) ? result : dout_q;

endmodule

// File: tb/tb_iter_div.sv
// Self-checking bench for iter_div: one unsigned and one signed instance,
// directed corner cases plus random operands against an arithmetic model.
module tb_iter_div;

   localparam int W   = 32;
   localparam int LAT = W + 2;
`ifdef DIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [1:0]    a_valid = '0, b_valid = '0;
   logic [W-1:0]  a_data = '0, b_data = '0;
   logic          a_ready_u, b_ready_u, dv_u;
   logic          a_ready_s, b_ready_s, dv_s;
   logic [2*W-1:0] dout_u, dout_s;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   iter_div #(.WIDTH(W), .SIGNED(1'b0)) u_div_u (
      .clk(clk), .resetn(resetn),
      .s_axis_dividend_tdata(a_data), .s_axis_dividend_tvalid(a_valid[0]),
      .s_axis_dividend_tready(a_ready_u),
      .s_axis_divisor_tdata(b_data), .s_axis_divisor_tvalid(b_valid[0]),
      .s_axis_divisor_tready(b_ready_u),
      .m_axis_dout_tdata(dout_u), .m_axis_dout_tvalid(dv_u)
   );

   iter_div #(.WIDTH(W), .SIGNED(1'b1)) u_div_s (
      .clk(clk), .resetn(resetn),
      .s_axis_dividend_tdata(a_data), .s_axis_dividend_tvalid(a_valid[1]),
      .s_axis_dividend_tready(a_ready_s),
      .s_axis_divisor_tdata(b_data), .s_axis_divisor_tvalid(b_valid[1]),
      .s_axis_divisor_tready(b_ready_s),
      .m_axis_dout_tdata(dout_s), .m_axis_dout_tvalid(dv_s)
   );

   function automatic logic a_rdy(input int sel);
      return (sel != 0) ? a_ready_s : a_ready_u;
   endfunction
   function automatic logic b_rdy(input int sel);
      return (sel != 0) ? b_ready_s : b_ready_u;
   endfunction
   function automatic logic dvld(input int sel);
      return (sel != 0) ? dv_s : dv_u;
   endfunction
   function automatic logic [2*W-1:0] dout(input int sel);
      return (sel != 0) ? dout_s : dout_u;
   endfunction

   // Reference: language-level division with the divider's special cases.
   function automatic logic [2*W-1:0] ref_div(input int sel, input logic [W-1:0] a, input logic [W-1:0] b);
      int sa, sb, q, r;
      if (b == 0) return {32'hFFFF_FFFF, a};
      if (sel == 0) return {a / b, a % b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
      sa = int'(a);
      sb = int'(b);
      q  = sa / sb;
      r  = sa % sb;
      return {q, r};
   endfunction

   function automatic int ref_lat(input int sel, input logic [W-1:0] a, input logic [W-1:0] b);
      longint ma, mb;
      ma = (sel != 0) ? longint'(int'(a)) : longint'(a);
      mb = (sel != 0) ? longint'(int'(b)) : longint'(b);
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
      if (EARLY && (b == 0 || ma < mb)) return 2;
      return LAT;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at the negedge of cycle 1; watches one operation to completion.
   task automatic watch(input int sel, input int lat, input logic [2*W-1:0] exp, input string tag);
      int n = 1;
      int pulses = 0;
      int first = -1;
      logic [2*W-1:0] got = '0;
      for (int k = 0; k < LAT + 6; k++) begin
         if (n == 1)
            check({tag, " busy"}, {62'b0, a_rdy(sel), b_rdy(sel)}, 64'd0);
         if (dvld(sel)) begin
            pulses++;
            if (first < 0) begin
               first = n;
               got   = dout(sel);
            end
         end
         @(negedge clk);
         n++;
      end
      check({tag, " latency"}, 64'(first), 64'(lat));
      check({tag, " pulses"}, 64'(pulses), 64'd1);
      check({tag, " data"}, got, exp);
      check({tag, " hold"}, dout(sel), exp);
   endtask

   task automatic run_op(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp, input int lat, input string tag);
      @(negedge clk);
      check({tag, " ready"}, {62'b0, a_rdy(sel), b_rdy(sel)}, 64'd3);
      a_data = a;
      b_data = b;
      a_valid[sel] = 1'b1;
      b_valid[sel] = 1'b1;
      @(negedge clk);
      a_valid = '0;
      b_valid = '0;
      watch(sel, lat, exp, tag);
   endtask

   initial begin
      int n, pulses, p1, p2, hs;
      logic [2*W-1:0] d1, d2;
      logic [W-1:0] ra, rb;
      int sel;

      repeat (3) @(negedge clk);
      check("reset dout_u", dout_u, 64'd0);
      check("reset dv", {62'b0, dv_u, dv_s}, 64'd0);
      resetn = 1'b1;
      @(negedge clk);
      check("reset rdy_u", {62'b0, a_ready_u, b_ready_u}, 64'd3);
      check("reset rdy_s", {62'b0, a_ready_s, b_ready_s}, 64'd3);

      // Directed corner cases
      run_op(0, 32'd100, 32'd7, {32'h0000_000E, 32'h0000_0002}, LAT, "u100/7");
      run_op(1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFD, 32'hFFFF_FFFF}, LAT, "s-7/2");
      run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, LAT, "s_ovf");
      run_op(0, 32'd5, 32'd0, {32'hFFFF_FFFF, 32'd5}, EARLY ? 2 : LAT, "u5/0");
      run_op(1, 32'd5, 32'd0, {32'hFFFF_FFFF, 32'd5}, EARLY ? 2 : LAT, "s5/0");
      run_op(1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFF, 32'hFFFF_FFFB}, EARLY ? 2 : LAT, "s-5/0");
      run_op(0, 32'd3, 32'd10, {32'h0, 32'd3}, EARLY ? 2 : LAT, "u3/10");
      run_op(1, 32'hFFFF_FFFD, 32'd10, {32'h0, 32'hFFFF_FFFD}, EARLY ? 2 : LAT, "s-3/10");

      // Staggered operands, a repeated dividend offer, and a back-to-back second op
      @(negedge clk);
      a_data = 32'd1000;
      a_valid[0] = 1'b1;
      @(negedge clk);
      check("stag dvd rdy", {63'b0, a_ready_u}, 64'd0);
      check("stag dvs rdy", {63'b0, b_ready_u}, 64'd1);
      a_data = 32'd555;
      @(negedge clk);
      @(negedge clk);
      a_valid[0] = 1'b0;
      b_data = 32'd9;
      b_valid[0] = 1'b1;
      @(negedge clk);
      a_data = 32'd77;
      b_data = 32'd5;
      a_valid[0] = 1'b1;
      n = 4; pulses = 0; p1 = -1; p2 = -1; hs = -1; d1 = '0; d2 = '0;
      for (int k = 0; k < 100; k++) begin
         if (dv_u) begin
            pulses++;
            if (pulses == 1) begin p1 = n; d1 = dout_u; end
            else begin p2 = n; d2 = dout_u; end
         end
         if (hs < 0 && a_valid[0] && a_ready_u && b_ready_u) hs = n;
         @(negedge clk);
         n++;
         if (hs >= 0) begin
            a_valid[0] = 1'b0;
            b_valid[0] = 1'b0;
         end
      end
      check("stag lat1", 64'(p1), 64'd37);
      check("stag data1", d1, {32'd111, 32'd1});
      check("stag hs2", 64'(hs), 64'd38);
      check("stag lat2", 64'(p2), 64'd72);
      check("stag data2", d2, {32'd15, 32'd2});
      check("stag pulses", 64'(pulses), 64'd2);

      // Reset in the middle of ITER aborts the operation silently
      @(negedge clk);
      a_data = 32'd1000;
      b_data = 32'd7;
      a_valid[0] = 1'b1;
      b_valid[0] = 1'b1;
      @(negedge clk);
      a_valid = '0;
      b_valid = '0;
      repeat (10) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("abort rdy", {60'b0, a_ready_u, b_ready_u, a_ready_s, b_ready_s}, 64'hF);
      check("abort dout", dout_u, 64'd0);
      pulses = 0;
      for (int k = 0; k < LAT + 6; k++) begin
         if (dv_u) pulses++;
         @(negedge clk);
      end
      check("abort no pulse", 64'(pulses), 64'd0);
      run_op(0, 32'd9, 32'd3, {32'd3, 32'd0}, LAT, "u9/3");

      // Random operands against the model
      for (int i = 0; i < 24; i++) begin
         sel = i % 2;
         ra  = $urandom;
         rb  = $urandom;
         case ((i / 2) % 4)
            0: rb = $urandom_range(1, 15);
            1: rb = rb >> $urandom_range(0, 31);
            2: ra = $urandom_range(0, 20);
            default: if (i % 8 == 6) rb = '0;
         endcase
         run_op(sel, ra, rb, ref_div(sel, ra, rb), ref_lat(sel, ra, rb),
                $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/iter_div.md
# iter_div

Iterative radix-2 restoring integer divider serving as the responder on the execute stage's divider interface. It accepts a dividend and a divisor on two independent valid/ready input channels and computes quotient and remainder over WIDTH+2 cycles. It returns both on a single valid-only output channel with no backpressure. One instance per signedness (SIGNED=1 for div.w/mod.w, SIGNED=0 for div.wu/mod.wu) sits beside the EX stage.

## Interface
- WIDTH, 32, operand width; dout is 2*WIDTH.
- SIGNED, 1, 1 = two's-complement operands and results; 0 = unsigned.

- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- s_axis_dividend_tdata  in  WIDTH  dividend.
- s_axis_dividend_tvalid  in  1  dividend valid.
- s_axis_dividend_tready  out  1  dividend accepted when high with tvalid.
- s_axis_divisor_tdata  in  WIDTH  divisor.
- s_axis_divisor_tvalid  in  1  divisor valid.
- s_axis_divisor_tready  out  1  divisor accepted when high with tvalid.
- m_axis_dout_tdata  out  2*WIDTH  {quotient[2W-1:W], remainder[W-1:0]}.
- m_axis_dout_tvalid  out  1  one-cycle result pulse; no tready.

## Operation
- Each input channel has a one-entry holding register plus a held flag. A channel's tready = (state==IDLE) & ~held. A handshake (tvalid & tready at a clock edge) latches the data and sets held.
- The two operands may arrive in the same cycle or in different cycles, in either order. A channel that is already held ignores further tvalid.
- FSM states: IDLE, PREP, ITER, DONE.
  - IDLE -> PREP on the edge at which both held flags are set or become set. Both held flags clear on entering PREP.
  - PREP: latch magnitudes (absolute values when SIGNED, raw otherwise). Record quotient sign = sign(dividend) XOR sign(divisor) and remainder sign = sign(dividend). Load a WIDTH-bit counter with WIDTH-1. Go to ITER.
  - ITER: one restoring step per cycle: shift {rem, quo} left by 1, trial-subtract the divisor, set the quotient LSB if there is no borrow. Leave after the counter reaches 0 (exactly WIDTH cycles) -> DONE.
  - DONE: apply sign fixup, drive tdata, assert tvalid for this cycle only. Go to IDLE.
- Sign rules (SIGNED=1): quotient negated if its sign is 1 and divisor != 0. Remainder negated if dividend is negative.
- Divide by zero, either signedness: quotient = all ones, remainder = dividend (original encoding).
- Signed overflow (−2^(W−1) / −1): quotient = 0x8000_0000, remainder = 0. No flag.
- m_axis_dout_tdata holds the last result until the next DONE. It is 0 after reset.

## Timing
- Cycle 0 = cycle of the later (or only) operand handshake. PREP is cycle 1, ITER is cycles 2..WIDTH+1, DONE (tvalid=1) is cycle WIDTH+2, i.e. 34 for WIDTH=32.
- Earliest next handshake is cycle WIDTH+3. Both treadies are low in PREP, ITER and DONE.
- Reset values: both treadies 1 (state IDLE, nothing held), m_axis_dout_tvalid 0, m_axis_dout_tdata 0.
- resetn low in any state, including mid-ITER: next edge returns to IDLE, clears held flags and counter, and no tvalid pulse for the aborted operation.
- No cycle-0 bypass. tvalid never asserts twice per operation.

## Configuration
- DIV_EARLY_OUT_EN defined: PREP goes directly to DONE when divisor == 0 or |dividend| < |divisor|. The result is then {0, dividend} for the magnitude case, or the divide-by-zero result for a zero divisor. tvalid comes at cycle 2, and the next handshake is earliest at cycle 3.
- DIV_EARLY_OUT_EN undefined: latency is always WIDTH+2, independent of data.

## Structure
- Package div_pkg: state encoding (IDLE/PREP/ITER/DONE localparams), default WIDTH, and the macro-dependent early-out localparam.
- Sub-module div_step: combinational single restoring step (inputs rem, quo, divisor; outputs next rem, next quo). Instantiated once in ITER.
- Everything else (holding registers, FSM, counter, fixup) stays in iter_div.

## Test plan
- SIGNED=0, dividend 100 and divisor 7 in the same cycle 0 -> tvalid at cycle 34 only, tdata = {0x0000000E, 0x00000002}.
- SIGNED=1, −7 (0xFFFFFFF9) / 2 -> {0xFFFFFFFD, 0xFFFFFFFF}. Also 0x80000000 / 0xFFFFFFFF -> {0x80000000, 0x00000000}.
- Either SIGNED, 5 / 0 -> {0xFFFFFFFF, 0x00000005} at cycle 34 (cycle 2 with DIV_EARLY_OUT_EN).
- Staggered operands: dividend at cycle 0, divisor at cycle 3 -> dividend tready low from cycle 1. Result is 34 cycles after cycle 3. A second op offered back-to-back is accepted at cycle 38 (relative to the first dividend), and a repeated dividend tvalid while held is ignored.
- resetn pulled low for one cycle at cycle 10 of ITER -> no tvalid ever for that op, tdata 0, both treadies 1 the cycle after reset releases. A new 9/3 then returns {3, 0}.
- DIV_EARLY_OUT_EN, SIGNED=0, 3 / 10 -> {0x00000000, 0x00000003} at cycle 2. Without the macro the same result arrives at cycle 34.
